rd_chunk_scheduler: RTL

- Sits directly upstream of the host-memory read-request TLP generator.
- Accepts a read job (host buffer base address plus length in qwords) and splits it into PCIe-legal read chunks.
- Presents chunks one at a time on the generator's read_chunk / read_chunk_ack handshake.
- Caps in-flight read requests using completion-done pulses from the RX completion path, and pulses job_done when the whole job has been requested and completed.

---
 rtl/rd_chunk_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rd_chunk_scheduler.sv
// Splits a host read job into chunks that never cross a 4 KB boundary or exceed
// the max read request, and issues them to the read TLP generator under a credit cap.
module rd_chunk_scheduler #(
   parameter int MAX_RD_QW       = 64,
   parameter int MAX_OUTSTANDING = 8,
   parameter int JOB_QW_W        = 19
) (
   input  logic                trn_clk,
   input  logic                reset_n,
   input  logic                job_valid,
   input  logic [63:0]         job_addr,
   input  logic [JOB_QW_W-1:0] job_qwords,
   output logic                job_ready,
   output logic                job_done,
   output logic [63:0]         huge_page_addr,
   output logic [8:0]          qwords_to_rd,
   output logic                read_chunk,
   input  logic                read_chunk_ack,
   input  logic                cpl_chunk_done,
   output logic [4:0]          outstanding,
   output logic                err_underflow
);

   // state   | meaning
   // IDLE    | waiting for a job, job_ready high
   // CALC    | size next chunk, wait for a free credit
   // REQ     | read_chunk held until the generator acks
   // HOLD    | one cycle of stable chunk outputs after ack, then advance pointer
   // DRAIN   | all chunks issued, wait for completions before job_done

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_HOLD, S_DRAIN} state_t;

   localparam logic [9:0] MAX_QW  = 10'(MAX_RD_QW);
   localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

   state_t              state_q, state_d;
   logic [63:0]         cur_addr_q, cur_addr_d;
   logic [JOB_QW_W-1:0] remaining_q, remaining_d;
   logic [8:0]          chunk_q, chunk_d;
   logic                job_ready_q, job_ready_d;
   logic                job_done_q, job_done_d;
   logic [63:0]         hp_addr_q, hp_addr_d;
   logic [8:0]          qwords_q, qwords_d;
   logic                read_chunk_q, read_chunk_d;
   logic [4:0]          out_q, out_d;
   logic                err_q, err_d;

   logic [9:0]          page_room;
   logic [9:0]          cap;
   logic [8:0]          chunk_calc;
   logic                ack_take;

   always_comb begin
      page_room  = 10'd512 - {1'b0, cur_addr_q[11:3]};
      cap        = (page_room < MAX_QW) ? page_room : MAX_QW;
      chunk_calc = (remaining_q < JOB_QW_W'(cap)) ? remaining_q[8:0] : cap[8:0];
      ack_take   = (state_q == S_REQ) && read_chunk_ack;

      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      chunk_d      = chunk_q;
      job_ready_d  = job_ready_q;
      job_done_d   = 1'b0;
      hp_addr_d    = hp_addr_q;
      qwords_d     = qwords_q;
      read_chunk_d = read_chunk_q;
      out_d        = out_q;
      err_d        = err_q;

      // Completions count in every state; an ack and a completion together cancel.
      if (ack_take && !cpl_chunk_done) begin
         out_d = out_q + 5'd1;
      end else if (!ack_take && cpl_chunk_done) begin
         if (out_q == 5'd0) err_d = 1'b1;
         else               out_d = out_q - 5'd1;
      end

      case (state_q)
         S_IDLE: begin
            job_ready_d = 1'b1;
            if (job_valid) begin
               if (job_qwords != '0) begin
                  cur_addr_d  = job_addr & ~64'h7;
                  remaining_d = job_qwords;
                  job_ready_d = 1'b0;
                  state_d     = S_CALC;
               end else begin
                  job_done_d = 1'b1;
               end
            end
         end
         S_CALC: begin
            chunk_d   = chunk_calc;
            qwords_d  = chunk_calc;
            hp_addr_d = cur_addr_q;
            if (out_q < MAX_OUT) begin
               read_chunk_d = 1'b1;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            if (read_chunk_ack) begin
               read_chunk_d = 1'b0;
               state_d      = S_HOLD;
            end
         end
         S_HOLD: begin
            cur_addr_d  = cur_addr_q + {52'd0, chunk_q, 3'd0};
            remaining_d = remaining_q - JOB_QW_W'(chunk_q);
            state_d     = (remaining_d == '0) ? S_DRAIN : S_CALC;
         end
         S_DRAIN: begin
            if (out_q == 5'd0) begin
               job_done_d  = 1'b1;
               job_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         chunk_q      <= '0;
         job_ready_q  <= 1'b1;
         job_done_q   <= 1'b0;
         hp_addr_q    <= '0;
         qwords_q     <= '0;
         read_chunk_q <= 1'b0;
         out_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         chunk_q      <= chunk_d;
         job_ready_q  <= job_ready_d;
         job_done_q   <= job_done_d;
         hp_addr_q    <= hp_addr_d;
         qwords_q     <= qwords_d;
         read_chunk_q <= read_chunk_d;
         out_q        <= out_d;
         err_q        <= err_d;
      end
   end

   assign job_ready      = job_ready_q;
   assign job_done       = job_done_q;
   assign huge_page_addr = hp_addr_q;
   assign qwords_to_rd   = qwords_q;
   assign read_chunk     = read_chunk_q;
   assign outstanding    = out_q;
   assign err_underflow  = err_q;

endmodule
